// File: rtl/sim_resp_checker.sv
// -----------------------------------------------------------------------------
// sim_resp_checker
//
// Response sink for the output stream of a unit under test. Each run accepts
// NUM_ITEMS words over a valid/ready handshake. Every word is compared against
// an internally generated ramp that starts at SEED and advances by STEP. The
// block counts mismatches, records the first failing word, and watches for
// stalls with a watchdog. It ends each run with a PASS, FAIL or TIMEOUT
// verdict.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset; aborts any run with no verdict
//   i_start    - one-cycle pulse that starts a run from IDLE or a terminal state
//   i_valid    - incoming word valid
//   i_data     - incoming word (DW bits)
//   o_ready    - checker accepts a word this cycle (combinational)
//   o_busy     - high while a run is in progress
//   o_done     - high in PASS/FAIL/TIMEOUT until the next start or reset
//   o_status   - 0 idle/running, 1 pass, 2 fail, 3 timeout
//   o_err_cnt  - mismatch count, saturating at 16'hFFFF
//   o_rx_cnt   - words accepted in this run
//   o_fail_idx - index of the first mismatching word
//   o_fail_dat - data of the first mismatching word
// -----------------------------------------------------------------------------
module sim_resp_checker #(
    parameter int unsigned DW          = 8,
    parameter int unsigned NUM_ITEMS   = 16,
    parameter logic [31:0] SEED        = 32'd0,
    parameter logic [31:0] STEP        = 32'd1,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [7:0]  BP_MASK     = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_status,
    output logic [15:0]   o_err_cnt,
    output logic [15:0]   o_rx_cnt,
    output logic [15:0]   o_fail_idx,
    output logic [DW-1:0] o_fail_dat
);

    localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
    localparam logic [DW-1:0]   SEED_T   = SEED[DW-1:0];
    localparam logic [DW-1:0]   STEP_T   = STEP[DW-1:0];
    localparam logic [15:0]     NUM_T    = 16'(NUM_ITEMS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      phase, phase_nxt;
    logic [WD_W-1:0] wdog, wdog_nxt;
    logic [DW-1:0]   expected, expected_nxt;
    logic [15:0]     err_cnt, err_cnt_nxt;
    logic [15:0]     rx_cnt, rx_cnt_nxt;
    logic [15:0]     fail_idx, fail_idx_nxt;
    logic [DW-1:0]   fail_dat, fail_dat_nxt;
    logic            accept;
    logic            mismatch;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign o_ready  = (state == ST_RUN) && BP_MASK[phase];
    assign accept   = i_valid && o_ready;
    assign mismatch = (i_data != expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            wdog     <= '0;
            expected <= '0;
            err_cnt  <= '0;
            rx_cnt   <= '0;
            fail_idx <= '0;
            fail_dat <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            wdog     <= wdog_nxt;
            expected <= expected_nxt;
            err_cnt  <= err_cnt_nxt;
            rx_cnt   <= rx_cnt_nxt;
            fail_idx <= fail_idx_nxt;
            fail_dat <= fail_dat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        wdog_nxt     = wdog;
        expected_nxt = expected;
        err_cnt_nxt  = err_cnt;
        rx_cnt_nxt   = rx_cnt;
        fail_idx_nxt = fail_idx;
        fail_dat_nxt = fail_dat;

        unique case (state)
            ST_RUN: begin
                // The back-pressure phase walks every RUN cycle, accepted or not.
                phase_nxt = phase + 3'd1;
                if (accept) begin
                    rx_cnt_nxt   = rx_cnt + 16'd1;
                    expected_nxt = expected + STEP_T;
                    wdog_nxt     = '0;
                    if (mismatch) begin
                        err_cnt_nxt = sat_inc16(err_cnt);
                        // Zero errors so far means this is the first failure.
                        if (err_cnt == 16'd0) begin
                            fail_idx_nxt = rx_cnt;
                            fail_dat_nxt = i_data;
                        end
                    end
                    // Completion is checked only on an accept, so it takes
                    // priority over the watchdog in the same cycle.
                    if (rx_cnt_nxt == NUM_T) begin
                        state_nxt = (err_cnt_nxt == 16'd0) ? ST_PASS : ST_FAIL;
                    end
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                    if (wdog_nxt == WD_LIMIT) begin
                        state_nxt = ST_TIMEOUT;
                    end
                end
            end
            default: begin
                // IDLE and the terminal states hold their outputs until a start.
                if (i_start) begin
                    state_nxt    = ST_RUN;
                    phase_nxt    = '0;
                    wdog_nxt     = '0;
                    expected_nxt = SEED_T;
                    err_cnt_nxt  = '0;
                    rx_cnt_nxt   = '0;
                    fail_idx_nxt = '0;
                    fail_dat_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        o_status = 2'd0;
        unique case (state)
            ST_PASS:    o_status = 2'd1;
            ST_FAIL:    o_status = 2'd2;
            ST_TIMEOUT: o_status = 2'd3;
            default:    o_status = 2'd0;
        endcase
    end

    assign o_busy     = (state == ST_RUN);
    assign o_done     = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
    assign o_err_cnt  = err_cnt;
    assign o_rx_cnt   = rx_cnt;
    assign o_fail_idx = fail_idx;
    assign o_fail_dat = fail_dat;

endmodule
